ram_arb: RTL and testbench

- Two-requester arbiter and sequencer for the single RAM/IO access port that feeds the RAM decoder.
- The decoder covers RAM0–RAM7 at 0x00–0x07 and the IO65 input at 0x41.
- Shares the port between the CPU core (requester 0) and the debug/loader interface (requester 1) using round-robin arbitration.
- Drives address, write data and write strobe, waits the decoder's read latency, and returns read data with a one-cycle ACK.

---
 rtl/ram_arb.sv | 190 +++++++++++++++++++
 tb/tb_ram_arb.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arb.sv
// ram_arb: two-requester round-robin arbiter and sequencer for the single
// RAM/IO access port in front of the RAM decoder (RAM0-RAM7 at 0x00-0x07,
// IO65 at 0x41).
//
// Ports
//   clk, n_reset                  clock (rising edge), async active-low reset
//   cpu_req/we/ad/wd -> cpu_ack/rd requester 0 (CPU core)
//   dbg_req/we/ad/wd -> dbg_ack/rd requester 1 (debug/loader), dbg_err
//   ram_ad, ram_wd, ram_we        access port towards the decoder
//   ram_rd                        decoder read data, stable RD_LAT edges
//                                 after ram_ad changes
//   busy                          high whenever the sequencer is not idle
//   owner                         current or last granted requester (1 = DBG)
//
// Optional feature (macro DBG_WP_EN): DBG writes outside RAM0-RAM7 are
// suppressed (no ram_we) and flagged on dbg_err together with dbg_ack.
// With the macro undefined, dbg_err stays 0 and every write passes through.
//
// state  | meaning
// IDLE   | port free, requests sampled, grant on this edge
// ACCESS | address/data driven; write ends after one cycle, read waits cnt
// DONE   | ACK cycle; return to IDLE on the next edge
module ram_arb #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_ad,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rd,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_ad,
    input  logic [DATA_W-1:0] dbg_wd,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rd,
    output logic              dbg_err,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_wd,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rd,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              op_we_q, op_we_d;
    logic              op_prot_q, op_prot_d;
    logic              owner_d;
    logic [ADDR_W-1:0] ram_ad_d;
    logic [DATA_W-1:0] ram_wd_d;
    logic              ram_we_d;
    logic              cpu_ack_d, dbg_ack_d, dbg_err_d;
    logic [DATA_W-1:0] cpu_rd_d, dbg_rd_d;

    logic              win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_ad;
    logic [DATA_W-1:0] sel_wd;
    logic              prot;

    // Under contention the requester that was not granted last wins.
    always_comb begin
        if (cpu_req && dbg_req)
            win = ~last_q;
        else
            win = dbg_req;
        sel_we = win ? dbg_we : cpu_we;
        sel_ad = win ? dbg_ad : cpu_ad;
        sel_wd = win ? dbg_wd : cpu_wd;
    end

`ifdef DBG_WP_EN
    // Only RAM0-RAM7 are writable from the debug side.
    assign prot = win & sel_we & (|sel_ad[ADDR_W-1:3]);
`else
    assign prot = 1'b0;
`endif

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        op_we_d   = op_we_q;
        op_prot_d = op_prot_q;
        owner_d   = owner;
        ram_ad_d  = ram_ad;
        ram_wd_d  = ram_wd;
        ram_we_d  = 1'b0;
        cpu_ack_d = 1'b0;
        dbg_ack_d = 1'b0;
        dbg_err_d = 1'b0;
        cpu_rd_d  = cpu_rd;
        dbg_rd_d  = dbg_rd;

        case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    ram_ad_d  = sel_ad;
                    ram_wd_d  = sel_wd;
                    ram_we_d  = sel_we & ~prot;
                    owner_d   = win;
                    last_d    = win;
                    op_we_d   = sel_we;
                    op_prot_d = prot;
                    cnt_d     = 2'(RD_LAT);
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (op_we_q) begin
                    if (owner) begin
                        dbg_ack_d = 1'b1;
                        dbg_err_d = op_prot_q;
                    end else begin
                        cpu_ack_d = 1'b1;
                    end
                    state_d = DONE;
                end else if (cnt_q == 2'd0) begin
                    if (owner) begin
                        dbg_rd_d  = ram_rd;
                        dbg_ack_d = 1'b1;
                    end else begin
                        cpu_rd_d  = ram_rd;
                        cpu_ack_d = 1'b1;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            last_q    <= 1'b1;
            op_we_q   <= 1'b0;
            op_prot_q <= 1'b0;
            owner     <= 1'b0;
            ram_ad    <= '0;
            ram_wd    <= '0;
            ram_we    <= 1'b0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            dbg_err   <= 1'b0;
            cpu_rd    <= '0;
            dbg_rd    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            op_we_q   <= op_we_d;
            op_prot_q <= op_prot_d;
            owner     <= owner_d;
            ram_ad    <= ram_ad_d;
            ram_wd    <= ram_wd_d;
            ram_we    <= ram_we_d;
            cpu_ack   <= cpu_ack_d;
            dbg_ack   <= dbg_ack_d;
            dbg_err   <= dbg_err_d;
            cpu_rd    <= cpu_rd_d;
            dbg_rd    <= dbg_rd_d;
        end
    end

endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: self-checking bench for ram_arb. A transaction-level model
// predicts every output cycle by cycle from grant times and fixed
// turnaround figures; directed phases add hand-computed expectations.
// A second instance with RD_LAT = 3 checks the longer read latency.
module tb_ram_arb;

    localparam int RL = 1;

    typedef struct {
        logic        we;
        logic [7:0]  ad;
        logic [15:0] wd;
    } txn_t;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_ad = 8'h00;
    logic [15:0] cpu_wd = 16'h0000;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [7:0]  dbg_ad = 8'h00;
    logic [15:0] dbg_wd = 16'h0000;
    logic        cpu_ack, dbg_ack, dbg_err, ram_we, busy, owner;
    logic [15:0] cpu_rd, dbg_rd, ram_wd, ram_rd;
    logic [7:0]  ram_ad;

    logic        c3_req = 1'b0, c3_we = 1'b0;
    logic [7:0]  c3_ad = 8'h00;
    logic [15:0] c3_wd = 16'h0000;
    logic        d3_req = 1'b0, d3_we = 1'b0;
    logic [7:0]  d3_ad = 8'h00;
    logic [15:0] d3_wd = 16'h0000;
    logic        c3_ack, d3_ack, d3_err, ram_we3, busy3, owner3;
    logic [15:0] c3_rd, d3_rd, ram_wd3, ram_rd3;
    logic [7:0]  ram_ad3;

    logic [15:0] mem [256];
    int          age1 = 7, age3 = 7;
    logic        bprev1 = 1'b0, bprev3 = 1'b0;

    int checks = 0;
    int failures = 0;

    txn_t cpu_q[$];
    txn_t dbg_q[$];

    ram_arb #(.ADDR_W(8), .DATA_W(16), .RD_LAT(RL)) dut (
        .clk(clk), .n_reset(n_reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ad(cpu_ad), .cpu_wd(cpu_wd),
        .cpu_ack(cpu_ack), .cpu_rd(cpu_rd),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_ad(dbg_ad), .dbg_wd(dbg_wd),
        .dbg_ack(dbg_ack), .dbg_rd(dbg_rd), .dbg_err(dbg_err),
        .ram_ad(ram_ad), .ram_wd(ram_wd), .ram_we(ram_we), .ram_rd(ram_rd),
        .busy(busy), .owner(owner)
    );

    ram_arb #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3)) dut3 (
        .clk(clk), .n_reset(n_reset),
        .cpu_req(c3_req), .cpu_we(c3_we), .cpu_ad(c3_ad), .cpu_wd(c3_wd),
        .cpu_ack(c3_ack), .cpu_rd(c3_rd),
        .dbg_req(d3_req), .dbg_we(d3_we), .dbg_ad(d3_ad), .dbg_wd(d3_wd),
        .dbg_ack(d3_ack), .dbg_rd(d3_rd), .dbg_err(d3_err),
        .ram_ad(ram_ad3), .ram_wd(ram_wd3), .ram_we(ram_we3), .ram_rd(ram_rd3),
        .busy(busy3), .owner(owner3)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int a);
        if (a == 'h41) return 16'h324F;
        if (a == 6)    return 16'h34B1;
        return 16'(16'h5A00 + a);
    endfunction

    // RAM bank: data becomes valid only once the address has been stable
    // for the decoder latency; before that it reads as 16'hDEAD.
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (ram_we) begin
            mem[ram_ad] <= ram_wd;
        end
    end

    assign ram_rd  = (age1 >= RL) ? mem[ram_ad]  : 16'hDEAD;
    assign ram_rd3 = (age3 >= 3)  ? mem[ram_ad3] : 16'hDEAD;

    initial forever begin
        @(negedge clk);
        if (busy && !bprev1) age1 = 0; else if (age1 < 7) age1++;
        if (busy3 && !bprev3) age3 = 0; else if (age3 < 7) age3++;
        bprev1 = busy;
        bprev3 = busy3;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester agents: hold REQ with the queue head until ACK is seen,
    // then retire it and present the next one.
    initial forever begin
        @(posedge clk);
        #2;
        if (!n_reset) begin
            cpu_req = 1'b0;
            dbg_req = 1'b0;
        end else begin
            if (cpu_req && cpu_ack) begin
                if (cpu_q.size() > 0) void'(cpu_q.pop_front());
                cpu_req = 1'b0;
            end
            if (!cpu_req && cpu_q.size() > 0) begin
                cpu_req = 1'b1; cpu_we = cpu_q[0].we; cpu_ad = cpu_q[0].ad; cpu_wd = cpu_q[0].wd;
            end
            if (dbg_req && dbg_ack) begin
                if (dbg_q.size() > 0) void'(dbg_q.pop_front());
                dbg_req = 1'b0;
            end
            if (!dbg_req && dbg_q.size() > 0) begin
                dbg_req = 1'b1; dbg_we = dbg_q[0].we; dbg_ad = dbg_q[0].ad; dbg_wd = dbg_q[0].wd;
            end
        end
    end

    // Model: an access granted at edge g0 drives the port from g0, ACKs after
    // 1 (write) or 1+RL (read) edges, and the port is free again at
    // g0+3 (write) or g0+RL+3 (read).
    int          cyc = 0;
    int          g0 = 0;
    int          free_at = 0;
    bit          have = 0;
    bit          m_last = 1, m_owner = 0, m_we_op = 0, m_prot = 0;
    logic [7:0]  m_ad = 8'h00;
    logic [15:0] m_wd = 16'h0000, m_crd = 16'h0000, m_drd = 16'h0000;
    logic [15:0] exp_mem [256];

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!n_reset) begin
            have = 0; free_at = 0; m_last = 1; m_owner = 0; m_we_op = 0; m_prot = 0;
            m_ad = 8'h00; m_wd = 16'h0000; m_crd = 16'h0000; m_drd = 16'h0000;
            for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
        end else begin
            if (have && !m_we_op && cyc == g0 + 1 + RL) begin
                if (m_owner) m_drd = exp_mem[m_ad];
                else         m_crd = exp_mem[m_ad];
            end
            if (cyc >= free_at && (cpu_req || dbg_req)) begin
                if (cpu_req && dbg_req) m_owner = (m_last == 1'b1) ? 1'b0 : 1'b1;
                else                    m_owner = dbg_req;
                m_last  = m_owner;
                m_we_op = m_owner ? dbg_we : cpu_we;
                m_ad    = m_owner ? dbg_ad : cpu_ad;
                m_wd    = m_owner ? dbg_wd : cpu_wd;
                m_prot  = 0;
`ifdef DBG_WP_EN
                if (m_owner && m_we_op && m_ad > 8'h07) m_prot = 1;
`endif
                if (m_we_op && !m_prot) exp_mem[m_ad] = m_wd;
                g0 = cyc;
                have = 1;
                free_at = g0 + (m_we_op ? 3 : RL + 3);
            end
        end
    end

    initial forever begin
        int  k, ack_k;
        bit  e_busy, e_we, e_cack, e_dack, e_err;
        @(negedge clk);
        k = cyc;
        ack_k  = g0 + (m_we_op ? 1 : RL + 1);
        e_busy = have && k >= g0 && k < g0 + (m_we_op ? 2 : RL + 2);
        e_we   = have && k == g0 && m_we_op && !m_prot;
        e_cack = have && !m_owner && k == ack_k;
        e_dack = have && m_owner && k == ack_k;
        e_err  = have && m_prot && k == ack_k;
        if (!n_reset) begin
            chk("rst_busy", busy, 0);     chk("rst_we", ram_we, 0);
            chk("rst_ad", ram_ad, 0);     chk("rst_wd", ram_wd, 0);
            chk("rst_cack", cpu_ack, 0);  chk("rst_dack", dbg_ack, 0);
            chk("rst_crd", cpu_rd, 0);    chk("rst_drd", dbg_rd, 0);
            chk("rst_err", dbg_err, 0);   chk("rst_owner", owner, 0);
        end else begin
            chk("busy", busy, e_busy);     chk("ram_we", ram_we, e_we);
            chk("ram_ad", ram_ad, m_ad);   chk("ram_wd", ram_wd, m_wd);
            chk("cpu_ack", cpu_ack, e_cack); chk("dbg_ack", dbg_ack, e_dack);
            chk("cpu_rd", cpu_rd, m_crd);  chk("dbg_rd", dbg_rd, m_drd);
            chk("dbg_err", dbg_err, e_err); chk("owner", owner, m_owner);
        end
    end

    int          ph_n, ph_we, ph_busy, ph_ack, ph_err, ph_grants, ph_alt_bad, ph_overlap, ph_first;
    logic [7:0]  ph_we_ad;
    logic [15:0] ph_we_wd;

    task automatic run_phase(input string name, input int max_cyc);
        bit done, pb, po;
        done = 0; pb = 0; po = 0;
        ph_n = 0; ph_we = 0; ph_busy = 0; ph_ack = -1; ph_err = 0;
        ph_grants = 0; ph_alt_bad = 0; ph_overlap = 0; ph_first = -1;
        ph_we_ad = 8'h00; ph_we_wd = 16'h0000;
        while (!done && ph_n < max_cyc) begin
            @(negedge clk);
            ph_n++;
            if (busy) ph_busy++;
            if (ram_we) begin ph_we++; ph_we_ad = ram_ad; ph_we_wd = ram_wd; end
            if ((cpu_ack || dbg_ack) && ph_ack < 0) begin ph_ack = ph_n; ph_err = int'(dbg_err); end
            if (cpu_ack && dbg_ack) ph_overlap++;
            if (busy && !pb) begin
                if (ph_grants > 0 && owner == po) ph_alt_bad++;
                if (ph_grants == 0) ph_first = int'(owner);
                po = owner;
                ph_grants++;
            end
            pb = busy;
            if (cpu_q.size() == 0 && dbg_q.size() == 0 && !cpu_req && !dbg_req && !busy && ph_n > 1)
                done = 1;
        end
        chk({name, "_done"}, 32'(done), 1);
    endtask

    function automatic txn_t mk(input logic we, input logic [7:0] ad, input logic [15:0] wd);
        txn_t t;
        t.we = we; t.ad = ad; t.wd = wd;
        return t;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("init_busy", busy, 0); chk("init_owner", owner, 0); chk("init_ad", ram_ad, 0);
        n_reset = 1'b1;

        // Reset one cycle after a CPU read grant.
        @(posedge clk); #1;
        cpu_q.push_back(mk(1'b0, 8'h41, 16'h0000));
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (busy) got = 1;
        end
        chk("midread_grant", 32'(got), 1);
        chk("midread_ad", ram_ad, 8'h41);
        @(posedge clk); #1;
        cpu_q.delete();
        n_reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0); chk("abort_ad", ram_ad, 0);
        chk("abort_ack", cpu_ack, 0); chk("abort_we", ram_we, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_reset = 1'b1;

        // First contention after reset goes to the CPU.
        @(posedge clk); #1;
        cpu_q.push_back(mk(1'b0, 8'h00, 16'h0000));
        dbg_q.push_back(mk(1'b0, 8'h05, 16'h0000));
        run_phase("postrst", 40);
        chk("postrst_first", ph_first, 0);
        chk("postrst_grants", ph_grants, 2);

        // CPU write 0x03 = 0xABCD.
        @(posedge clk); #1;
        cpu_q.push_back(mk(1'b1, 8'h03, 16'hABCD));
        run_phase("wr", 20);
        chk("wr_we_cycles", ph_we, 1); chk("wr_we_ad", ph_we_ad, 8'h03);
        chk("wr_we_wd", ph_we_wd, 16'hABCD); chk("wr_ack_at", ph_ack, 3);
        chk("wr_busy_cycles", ph_busy, 2);

        // CPU read IO65, latency 1.
        @(posedge clk); #1;
        cpu_q.push_back(mk(1'b0, 8'h41, 16'h0000));
        run_phase("rd1", 20);
        chk("rd1_ack_at", ph_ack, 4); chk("rd1_data", cpu_rd, 16'h324F);
        chk("rd1_busy_cycles", ph_busy, 3); chk("rd1_we_cycles", ph_we, 0);

        // CPU read IO65 on the latency-3 instance.
        @(posedge clk); #1;
        c3_req = 1'b1; c3_we = 1'b0; c3_ad = 8'h41;
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (c3_ack) got = 1;
        end
        chk("rd3_ack_seen", 32'(got), 1); chk("rd3_ack_at", n, 6);
        chk("rd3_data", c3_rd, 16'h324F); chk("rd3_owner", owner3, 0);
        chk("rd3_dack", d3_ack, 0); chk("rd3_drd", d3_rd, 0); chk("rd3_err", d3_err, 0);
        chk("rd3_we", ram_we3, 0); chk("rd3_wd", ram_wd3, 0); chk("rd3_ad", ram_ad3, 8'h41);
        @(posedge clk); #1;
        c3_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rd3_idle", busy3, 0);

        // DBG read RAM6 while the CPU is idle.
        cpu_q.delete();
        dbg_q.push_back(mk(1'b0, 8'h06, 16'h0000));
        run_phase("dbgrd", 20);
        chk("dbgrd_data", dbg_rd, 16'h34B1); chk("dbgrd_cpu_hold", cpu_rd, 16'h324F);
        chk("dbgrd_ack_at", ph_ack, 4);

        // Six accesses under continuous contention.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            cpu_q.push_back(mk(1'b0, 8'h00, 16'h0000));
            dbg_q.push_back(mk(1'b1, 8'h07, 16'h808D));
        end
        run_phase("cont", 60);
        chk("cont_grants", ph_grants, 6); chk("cont_first", ph_first, 0);
        chk("cont_alternate", ph_alt_bad, 0); chk("cont_overlap", ph_overlap, 0);
        chk("cont_we_cycles", ph_we, 3); chk("cont_cpu_rd", cpu_rd, 16'h5A00);

        // DBG write to IO65.
        @(posedge clk); #1;
        dbg_q.push_back(mk(1'b1, 8'h41, 16'h1234));
        run_phase("dbgwr", 20);
        chk("dbgwr_ack_at", ph_ack, 3);
`ifdef DBG_WP_EN
        chk("dbgwr_we_cycles", ph_we, 0); chk("dbgwr_err", ph_err, 1);
`else
        chk("dbgwr_we_cycles", ph_we, 1); chk("dbgwr_err", ph_err, 0);
`endif

        @(posedge clk); #1;
        cpu_q.push_back(mk(1'b0, 8'h41, 16'h0000));
        run_phase("rdback", 20);
`ifdef DBG_WP_EN
        chk("rdback_data", cpu_rd, 16'h324F);
`else
        chk("rdback_data", cpu_rd, 16'h1234);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
